// File: rtl/fsk_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fsk_bit_sequencer
// Purpose  : Serialises a DATA_W-bit word MSB first onto the H_L tone select
//            of a frequency divider. Each bit lasts CYC_PER_BIT divider carry
//            pulses. An init strobe reloads the divider at every bit boundary.
// Options  : define FSK_PARITY_EN to append one even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
module fsk_bit_sequencer #(
  parameter int DATA_W      = 8,
  parameter int CYC_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              co,
  output logic              H_L,
  output logic              init,
  output logic              busy,
  output logic              done
);

  localparam int                 c_BIT_W    = $clog2(DATA_W + 1);
  localparam logic [7:0]         c_CO_TC    = 8'(CYC_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef FSK_PARITY_EN
    ,
    PAR  = 2'd2
`endif
  } state_t;

  state_t               r_state, w_state;
  logic [DATA_W-1:0]    r_word, w_word;
  logic [c_BIT_W-1:0]   r_bit_cnt, w_bit_cnt;
  logic [7:0]           r_co_cnt, w_co_cnt;
  logic                 r_hl, w_hl;
  logic                 r_init, w_init;
  logic                 r_done, w_done;
  logic                 w_tc;
  logic [DATA_W-1:0]    w_shifted;

  // Terminal co pulse of the current bit period.
  assign w_tc = co && (r_co_cnt == c_CO_TC);

  // The word stays untouched for the whole frame; the next bit is selected
  // by shifting a copy so that its MSB is the bit about to be sent.
  assign w_shifted = r_word << (r_bit_cnt + 1'b1);

  // Next-state and next-output logic.
  always_comb begin
    w_state   = r_state;
    w_word    = r_word;
    w_bit_cnt = r_bit_cnt;
    w_co_cnt  = r_co_cnt;
    w_hl      = r_hl;
    w_init    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        // A co coincident with the accepted start is deliberately not counted.
        if (start) begin
          w_state   = SEND;
          w_word    = data;
          w_bit_cnt = '0;
          w_co_cnt  = '0;
          w_hl      = data[DATA_W-1];
          w_init    = 1'b1;
        end
      end
      SEND: begin
        if (w_tc) begin
          w_co_cnt = '0;
          if (r_bit_cnt == c_LAST_BIT) begin
`ifdef FSK_PARITY_EN
            w_state = PAR;
            w_hl    = ^r_word;
            w_init  = 1'b1;
`else
            w_state   = IDLE;
            w_bit_cnt = '0;
            w_hl      = 1'b0;
            w_done    = 1'b1;
`endif
          end else begin
            w_bit_cnt = r_bit_cnt + 1'b1;
            w_hl      = w_shifted[DATA_W-1];
            w_init    = 1'b1;
          end
        end else if (co) begin
          w_co_cnt = r_co_cnt + 8'd1;
        end
      end
`ifdef FSK_PARITY_EN
      PAR: begin
        if (w_tc) begin
          w_state   = IDLE;
          w_co_cnt  = '0;
          w_bit_cnt = '0;
          w_hl      = 1'b0;
          w_done    = 1'b1;
        end else if (co) begin
          w_co_cnt = r_co_cnt + 8'd1;
        end
      end
`endif
      default: begin
        w_state = IDLE;
        w_hl    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_bit_cnt <= '0;
      r_co_cnt  <= '0;
      r_hl      <= 1'b0;
      r_init    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_word    <= w_word;
      r_bit_cnt <= w_bit_cnt;
      r_co_cnt  <= w_co_cnt;
      r_hl      <= w_hl;
      r_init    <= w_init;
      r_done    <= w_done;
    end
  end

  assign H_L  = r_hl;
  assign init = r_init;
  assign done = r_done;
  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fsk_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsk_bit_sequencer
// Purpose  : Self-checking bench for fsk_bit_sequencer. Two instances
//            (CYC_PER_BIT = 4 and 1) share one stimulus stream; each cycle's
//            outputs are compared against a co-count based frame model.
//            Honours FSK_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsk_bit_sequencer;

  localparam int DATA_W = 8;
  localparam int MAXC   = 320;
`ifdef FSK_PARITY_EN
  localparam int NBITS  = DATA_W + 1;
`else
  localparam int NBITS  = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst, start, co;
  logic [DATA_W-1:0] data;
  logic              hl4, init4, busy4, done4;
  logic              hl1, init1, busy1, done1;

  int vectors    = 0;
  int miscompares = 0;

  // Stimulus per cycle index c (sampled at edge c) and outputs seen after it.
  logic              s_rst [MAXC];
  logic              s_st  [MAXC];
  logic              s_co  [MAXC];
  logic [DATA_W-1:0] s_dt  [MAXC];
  logic [3:0]        o4    [MAXC];   // {busy, done, init, H_L}
  logic [3:0]        o1    [MAXC];
  logic [3:0]        ex    [MAXC];
  int                len;

  always #5 clk = ~clk;

  fsk_bit_sequencer #(.DATA_W(DATA_W), .CYC_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .data(data), .co(co),
    .H_L(hl4), .init(init4), .busy(busy4), .done(done4)
  );

  fsk_bit_sequencer #(.DATA_W(DATA_W), .CYC_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .data(data), .co(co),
    .H_L(hl1), .init(init1), .busy(busy1), .done(done1)
  );

  // Bits of a frame in transmit order, first bit in the MSB.
  function automatic logic [NBITS-1:0] frame_bits(input logic [DATA_W-1:0] d);
`ifdef FSK_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Every stimulus run begins with two reset cycles.
  task automatic clear_stim(input int n);
    len = n;
    for (int c = 0; c < n; c++) begin
      s_rst[c] = (c >= 2);
      s_st[c]  = 1'b0;
      s_co[c]  = 1'b0;
      s_dt[c]  = DATA_W'($urandom);
    end
  endtask

  task automatic add_co(input int first, input int gap);
    for (int c = first; c < len; c += gap) s_co[c] = 1'b1;
  endtask

  // Inputs change on the falling edge, outputs are captured on the next one.
  task automatic run_stim();
    for (int c = 0; c < len; c++) begin
      rst = s_rst[c]; start = s_st[c]; co = s_co[c]; data = s_dt[c];
      @(posedge clk);
      @(negedge clk);
      o4[c] = {busy4, done4, init4, hl4};
      o1[c] = {busy1, done1, init1, hl1};
    end
    start = 1'b0; co = 1'b0;
  endtask

  // Frame model: a frame is NBITS*cyc counted co pulses long; bit k covers
  // counted pulses k*cyc .. (k+1)*cyc-1 and its reload strobe follows the
  // pulse that opens it.
  task automatic model(input int cyc);
    bit               act;
    int               cnt;
    logic [NBITS-1:0] bits;
    act = 0; cnt = 0; bits = '0;
    for (int c = 0; c < len; c++) begin
      if (!s_rst[c]) begin
        act = 0; ex[c] = 4'b0000;
      end else if (act && s_co[c]) begin
        cnt++;
        if (cnt == NBITS * cyc) begin
          act = 0; ex[c] = 4'b0100;
        end else begin
          ex[c] = {1'b1, 1'b0, (cnt % cyc) == 0, bits[NBITS-1-cnt/cyc]};
        end
      end else if (act) begin
        ex[c] = {2'b10, 1'b0, bits[NBITS-1-cnt/cyc]};
      end else if (s_st[c]) begin
        act = 1; cnt = 0; bits = frame_bits(s_dt[c]);
        ex[c] = {2'b10, 1'b1, bits[NBITS-1]};
      end else begin
        ex[c] = 4'b0000;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; co = 1'b0; data = '0;
    #1;
    vectors++;
    if ({busy4, done4, init4, hl4, busy1, done1, init1, hl1} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_values: got %b exp 00000000",
               {busy4, done4, init4, hl4, busy1, done1, init1, hl1});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; data = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy4, init4, hl4, busy1, init1, hl1} !== 6'b111111) begin
      miscompares++;
      $display("FAIL reset_first_start: got %b exp 111111",
               {busy4, init4, hl4, busy1, init1, hl1});
    end
    repeat (5) begin co = 1'b1; @(negedge clk); co = 1'b0; @(negedge clk); end
    vectors++;
    if ({busy4, busy1} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_midframe_busy: got %b exp 11", {busy4, busy1});
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy4, done4, init4, hl4, busy1, done1, init1, hl1} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_immediate: got %b exp 00000000",
               {busy4, done4, init4, hl4, busy1, done1, init1, hl1});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    logic [NBITS-1:0] fb;
    int ninit, dcyc, tcyc, nco;
    clear_stim(140);
    s_st[3] = 1'b1; s_dt[3] = 8'hA5;
    add_co(4, 3);
    run_stim();
    model(4);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o4[c] !== ex[c]) begin miscompares++; $display("FAIL nominal_c4 cycle %0d: got %b exp %b", c, o4[c], ex[c]); end
    end
    model(1);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o1[c] !== ex[c]) begin miscompares++; $display("FAIL nominal_c1 cycle %0d: got %b exp %b", c, o1[c], ex[c]); end
    end
`ifdef FSK_PARITY_EN
    fb = 9'b1010_0101_0;
`else
    fb = 8'b1010_0101;
`endif
    ninit = 0; dcyc = -1; tcyc = -1; nco = 0;
    for (int c = 0; c < len; c++) begin
      if (o4[c][1]) begin
        if (ninit < NBITS) begin
          vectors++;
          if (o4[c][0] !== fb[NBITS-1-ninit]) begin
            miscompares++;
            $display("FAIL nominal_bit%0d: got %b exp %b", ninit, o4[c][0], fb[NBITS-1-ninit]);
          end
        end
        ninit++;
      end
      if (o4[c][2] && dcyc < 0) dcyc = c;
      if (c > 3 && s_co[c]) begin nco++; if (nco == NBITS * 4) tcyc = c; end
    end
    vectors++;
    if (ninit !== NBITS) begin miscompares++; $display("FAIL nominal_init_count: got %0d exp %0d", ninit, NBITS); end
    vectors++;
    if (dcyc !== tcyc) begin miscompares++; $display("FAIL nominal_done_time: got %0d exp %0d", dcyc, tcyc); end
  endtask

  task automatic test_busy_start();
    int ninit;
    clear_stim(140);
    s_st[3] = 1'b1; s_dt[3] = 8'hA5;
    add_co(4, 3);
    s_st[31] = 1'b1; s_dt[31] = 8'hFF;   // tenth co of the frame
    run_stim();
    model(4);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o4[c] !== ex[c]) begin miscompares++; $display("FAIL busy_start_c4 cycle %0d: got %b exp %b", c, o4[c], ex[c]); end
    end
    model(1);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o1[c] !== ex[c]) begin miscompares++; $display("FAIL busy_start_c1 cycle %0d: got %b exp %b", c, o1[c], ex[c]); end
    end
    ninit = 0;
    for (int c = 0; c < len; c++) if (o4[c][1]) ninit++;
    vectors++;
    if (ninit !== NBITS) begin miscompares++; $display("FAIL busy_start_init_count: got %0d exp %0d", ninit, NBITS); end
  endtask

  task automatic test_start_co();
    clear_stim(140);
    s_st[3] = 1'b1; s_dt[3] = 8'h3C;
    add_co(3, 3);                        // first co coincides with start
    run_stim();
    model(4);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o4[c] !== ex[c]) begin miscompares++; $display("FAIL start_co_c4 cycle %0d: got %b exp %b", c, o4[c], ex[c]); end
    end
    model(1);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o1[c] !== ex[c]) begin miscompares++; $display("FAIL start_co_c1 cycle %0d: got %b exp %b", c, o1[c], ex[c]); end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    clear_stim(250);
    s_st[3] = 1'b1; s_dt[3] = 8'h5A;
    add_co(4, 3);
    model(4);
    d = -1;
    for (int c = 0; c < len; c++) if (ex[c][2] && d < 0) d = c;
    if (d < 0) d = 120;
    s_st[d+1] = 1'b1; s_dt[d+1] = 8'h07;   // start while done is showing
    run_stim();
    model(4);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o4[c] !== ex[c]) begin miscompares++; $display("FAIL b2b_c4 cycle %0d: got %b exp %b", c, o4[c], ex[c]); end
    end
    model(1);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o1[c] !== ex[c]) begin miscompares++; $display("FAIL b2b_c1 cycle %0d: got %b exp %b", c, o1[c], ex[c]); end
    end
    vectors++;
    if ({o4[d][2], o4[d+1][1]} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_init_after_done: got %b exp 11", {o4[d][2], o4[d+1][1]});
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    clear_stim(175);
    s_st[3] = 1'b1; s_dt[3] = 8'hC3;
    add_co(4, 3);
    s_rst[41] = 1'b0; s_rst[42] = 1'b0;  // after the 13th co at cycle 40
    s_st[45] = 1'b1; s_dt[45] = 8'h96;
    run_stim();
    model(4);
    for (int c = 0; c < len; c++) begin
      vectors++;
      if (o4[c] !== ex[c]) begin miscompares++; $display("FAIL reset_mid_c4 cycle %0d: got %b exp %b", c, o4[c], ex[c]); end
    end
    ndone = 0;
    for (int c = 0; c < len; c++) if (o4[c][2]) ndone++;
    vectors++;
    if (ndone !== 1) begin miscompares++; $display("FAIL reset_mid_done_count: got %0d exp 1", ndone); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_stim(MAXC);
      for (int c = 3; c < len; c += $urandom_range(1, 4)) s_co[c] = 1'b1;
      for (int c = 2; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) s_st[c] = 1'b1;
        if ($urandom_range(0, 99) == 0) s_rst[c] = 1'b0;
      end
      s_st[3] = 1'b1;
      run_stim();
      model(4);
      for (int c = 0; c < len; c++) begin
        vectors++;
        if (o4[c] !== ex[c]) begin miscompares++; $display("FAIL random%0d_c4 cycle %0d: got %b exp %b", it, c, o4[c], ex[c]); end
      end
      model(1);
      for (int c = 0; c < len; c++) begin
        vectors++;
        if (o1[c] !== ex[c]) begin miscompares++; $display("FAIL random%0d_c1 cycle %0d: got %b exp %b", it, c, o1[c], ex[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_busy_start();
    test_start_co();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
